beat_track_controller: RTL and testbench



---
 rtl/beat_pkg.sv | 22 ++
 rtl/beat_track_ram.sv | 26 ++
 rtl/beat_track_controller.sv | 169 ++++++++++++++++
 tb/tb_beat_track_controller.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// Shared definitions for the beat track recorder/player: key width, controller
// state encoding (values double as the external mode code) and RAM entry layout.
package beat_pkg;

  localparam int unsigned KEY_W = 7;

  // Encoding is visible on the mode output, so keep values fixed.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRec  = 2'd1,
    StPlay = 2'd2
  } state_e;

  // Entry layout: {key, length}. Length occupies the low bits.
  localparam int unsigned LEN_LSB = 0;

  // Key field sits directly above the length field.
  function automatic int unsigned key_lsb(input int unsigned len_w);
    return len_w;
  endfunction

endpackage

// File: rtl/beat_track_ram.sv
// Single-port track storage: write-first, synchronous read with one cycle of
// latency. Contents are never cleared.
module track_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 23
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // One access per cycle; a write also presents the written word on rdata.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/beat_track_controller.sv
// Record/playback sequencer for two run-length coded beat tracks sharing one
// single-port RAM. Track A occupies the lower half, track B the upper half.
module beat_track_controller
  import beat_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] ascii,
  input  logic             rec_req,
  input  logic             play_req,
  input  logic             track_sel,
  output logic [KEY_W-1:0] note,
  output logic             note_valid,
  output logic             busy,
  output logic             full,
  output logic [1:0]       mode
);

  localparam int unsigned WORD_W  = KEY_W + LEN_W;
  localparam int unsigned KEY_LSB = key_lsb(LEN_W);

  state_e             state_q;
  logic               track_q;
  logic [ADDR_W-1:0]  wr_ptr_q;
  logic [ADDR_W-1:0]  rd_ptr_q;   // index of the entry currently held in rdata
  logic [KEY_W-1:0]   prev_key_q;
  logic [LEN_W-1:0]   run_q;
  logic [LEN_W-1:0]   remain_q;
  logic [KEY_W-1:0]   note_q;
  logic               note_valid_q;
  logic               full_q;
  logic [ADDR_W:0]    track_len_a_q;
  logic [ADDR_W:0]    track_len_b_q;

  logic               ram_we;
  logic [ADDR_W:0]    ram_addr;
  logic [WORD_W-1:0]  ram_wdata;
  logic [WORD_W-1:0]  ram_rdata;

  logic [ADDR_W:0]    sel_len;
  logic [ADDR_W:0]    act_len;
  logic [ADDR_W:0]    rd_inc;
  logic [ADDR_W-1:0]  rd_next;
  logic [ADDR_W:0]    done_len;
  logic               rec_done;
  logic               play_load;

  assign sel_len  = track_sel ? track_len_b_q : track_len_a_q;
  assign act_len  = track_q ? track_len_b_q : track_len_a_q;
  // Writing entry 2**ADDR_W-1 naturally yields a length of 2**ADDR_W.
  assign done_len = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
  assign rec_done = ram_we && (!rec_req || (wr_ptr_q == '1));
  // Load a new active entry before the first note and on the last cycle of each run.
  assign play_load = (state_q == StPlay) && play_req &&
                     (!note_valid_q || (remain_q == LEN_W'(1)));

  // Next playback index, wrapping at the recorded track length.
  always_comb begin
    rd_inc  = {1'b0, rd_ptr_q} + (ADDR_W+1)'(1);
    rd_next = (rd_inc == act_len) ? '0 : rd_inc[ADDR_W-1:0];
  end

  // RAM port steering: prefetch entry 0 in IDLE, write runs in REC, read ahead in PLAY.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = {track_q, rd_ptr_q};
    ram_wdata = '0;
    ram_wdata[KEY_LSB +: KEY_W] = prev_key_q;
    ram_wdata[LEN_LSB +: LEN_W] = run_q;
    unique case (state_q)
      StIdle: ram_addr = {track_sel, {ADDR_W{1'b0}}};
      StRec: begin
        ram_addr = {track_q, wr_ptr_q};
        ram_we   = !rec_req || (ascii != prev_key_q) || (run_q == '1);
      end
      StPlay: begin
        // Holding the address keeps the prefetched entry stable in rdata.
        if (play_load) ram_addr = {track_q, rd_next};
      end
      default: ;
    endcase
  end

  track_ram #(
    .AW (ADDR_W + 1),
    .DW (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Controller FSM with run-length encoder and playback counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      track_q       <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      prev_key_q    <= '0;
      run_q         <= '0;
      remain_q      <= '0;
      note_q        <= '0;
      note_valid_q  <= 1'b0;
      full_q        <= 1'b0;
      track_len_a_q <= '0;
      track_len_b_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rec_req) begin
            track_q    <= track_sel;
            wr_ptr_q   <= '0;
            prev_key_q <= ascii;
            run_q      <= LEN_W'(1);
            full_q     <= 1'b0;
            state_q    <= StRec;
          end else if (play_req && (sel_len != '0)) begin
            track_q  <= track_sel;
            rd_ptr_q <= '0;
            state_q  <= StPlay;
          end
        end
        StRec: begin
          if (rec_done) begin
            if (wr_ptr_q == '1) full_q <= 1'b1;
            if (track_q) track_len_b_q <= done_len;
            else         track_len_a_q <= done_len;
            state_q <= StIdle;
          end else if (ram_we) begin
            // Key change or saturated run: entry written, start a fresh run.
            wr_ptr_q   <= wr_ptr_q + ADDR_W'(1);
            prev_key_q <= ascii;
            run_q      <= LEN_W'(1);
          end else begin
            run_q <= run_q + LEN_W'(1);
          end
        end
        StPlay: begin
          if (!play_req) begin
            note_q       <= '0;
            note_valid_q <= 1'b0;
            state_q      <= StIdle;
          end else if (play_load) begin
            note_q       <= ram_rdata[KEY_LSB +: KEY_W];
            remain_q     <= ram_rdata[LEN_LSB +: LEN_W];
            rd_ptr_q     <= rd_next;
            note_valid_q <= 1'b1;
          end else begin
            remain_q <= remain_q - LEN_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign full       = full_q;
  assign busy       = (state_q != StIdle);
  assign mode       = state_q;

endmodule

// File: tb/tb_beat_track_controller.sv
// Directed bench for beat_track_controller. Three instances share the stimulus:
// the default configuration, a 3-bit run length and a 4-entry track.
module tb_beat_track_controller;

  logic       clk;
  logic       reset;
  logic [6:0] ascii;
  logic       rec_req;
  logic       play_req;
  logic       track_sel;

  logic [6:0] note, note_l, note_a;
  logic       note_valid, note_valid_l, note_valid_a;
  logic       busy, busy_l, busy_a;
  logic       full, full_l, full_a;
  logic [1:0] mode, mode_l, mode_a;

  int checks;
  int fails;

  beat_track_controller #(.ADDR_W(8), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .ascii(ascii), .rec_req(rec_req), .play_req(play_req),
    .track_sel(track_sel), .note(note), .note_valid(note_valid), .busy(busy),
    .full(full), .mode(mode)
  );

  beat_track_controller #(.ADDR_W(8), .LEN_W(3)) dut_l (
    .clk(clk), .reset(reset), .ascii(ascii), .rec_req(rec_req), .play_req(play_req),
    .track_sel(track_sel), .note(note_l), .note_valid(note_valid_l), .busy(busy_l),
    .full(full_l), .mode(mode_l)
  );

  beat_track_controller #(.ADDR_W(2), .LEN_W(16)) dut_a (
    .clk(clk), .reset(reset), .ascii(ascii), .rec_req(rec_req), .play_req(play_req),
    .track_sel(track_sel), .note(note_a), .note_valid(note_valid_a), .busy(busy_a),
    .full(full_a), .mode(mode_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; ascii = '0; rec_req = 1'b0; play_req = 1'b0; track_sel = 1'b0;
    #2;
    checks++;
    if ({note, note_valid, busy, full, mode} !== 12'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {note, note_valid, busy, full, mode});
    end
    tick; tick;
    reset = 1'b0;
    tick;
    checks++;
    if (mode !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got mode %0d busy %0d expected 0 0", mode, busy);
    end
  endtask

  task automatic test_record_a;
    track_sel = 1'b0; rec_req = 1'b1; ascii = 7'd65;
    tick;
    checks++;
    if (mode !== 2'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rec_enter: got mode %0d busy %0d expected 1 1", mode, busy);
    end
    tick; tick;
    ascii = 7'd66;
    tick; tick;
    rec_req = 1'b0;
    tick;
    checks++;
    if (mode !== 2'd0 || full !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rec_a_exit: got mode %0d full %0d busy %0d expected 0 0 0",
               mode, full, busy);
    end
    checks++;
    if (dut.u_ram.mem[0] !== {7'd65, 16'd3} || dut.u_ram.mem[1] !== {7'd66, 16'd2}) begin
      fails++;
      $display("FAIL rec_a_entries: got %h %h expected %h %h", dut.u_ram.mem[0],
               dut.u_ram.mem[1], {7'd65, 16'd3}, {7'd66, 16'd2});
    end
    checks++;
    if (dut.track_len_a_q !== 9'd2) begin
      fails++;
      $display("FAIL rec_a_len: got %0d expected 2", dut.track_len_a_q);
    end
  endtask

  task automatic test_play_a;
    logic [6:0] exp_seq [10];
    exp_seq = '{7'd65, 7'd65, 7'd65, 7'd66, 7'd66, 7'd65, 7'd65, 7'd65, 7'd66, 7'd66};
    track_sel = 1'b0; play_req = 1'b1;
    tick;
    checks++;
    if (note_valid !== 1'b0 || mode !== 2'd2) begin
      fails++;
      $display("FAIL play_a_latency: got valid %0d mode %0d expected 0 2", note_valid, mode);
    end
    tick;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (note_valid !== 1'b1 || note !== exp_seq[i]) begin
        fails++;
        $display("FAIL play_a_seq[%0d]: got valid %0d note %0d expected 1 %0d",
                 i, note_valid, note, exp_seq[i]);
      end
      tick;
    end
    play_req = 1'b0;
    tick;
    checks++;
    if (note_valid !== 1'b0 || note !== 7'd0 || mode !== 2'd0) begin
      fails++;
      $display("FAIL play_a_stop: got valid %0d note %0d mode %0d expected 0 0 0",
               note_valid, note, mode);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp_a [5];
    exp_a = '{7'd65, 7'd65, 7'd65, 7'd66, 7'd66};
    track_sel = 1'b1; rec_req = 1'b1; ascii = 7'd10;
    tick;
    ascii = 7'd11; tick;
    ascii = 7'd10; tick;
    ascii = 7'd11; tick;
    rec_req = 1'b0;
    tick;
    checks++;
    if (dut.track_len_b_q !== 9'd4 || dut.track_len_a_q !== 9'd2) begin
      fails++;
      $display("FAIL rec_b_len: got b %0d a %0d expected 4 2",
               dut.track_len_b_q, dut.track_len_a_q);
    end
    play_req = 1'b1;
    tick; tick;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (note_valid !== 1'b1 || note !== ((i % 2 == 0) ? 7'd10 : 7'd11)) begin
        fails++;
        $display("FAIL play_b_seq[%0d]: got valid %0d note %0d expected 1 %0d",
                 i, note_valid, note, (i % 2 == 0) ? 10 : 11);
      end
      tick;
    end
    play_req = 1'b0;
    tick;
    track_sel = 1'b0; play_req = 1'b1;
    tick; tick;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (note_valid !== 1'b1 || note !== exp_a[i]) begin
        fails++;
        $display("FAIL replay_a_seq[%0d]: got valid %0d note %0d expected 1 %0d",
                 i, note_valid, note, exp_a[i]);
      end
      tick;
    end
    play_req = 1'b0;
    tick;
  endtask

  task automatic test_run_saturation;
    track_sel = 1'b0; rec_req = 1'b1; ascii = 7'd70;
    repeat (10) tick;
    ascii = 7'd71;
    tick;
    rec_req = 1'b0;
    tick;
    checks++;
    if (dut_l.u_ram.mem[0] !== {7'd70, 3'd7} || dut_l.u_ram.mem[1] !== {7'd70, 3'd3} ||
        dut_l.u_ram.mem[2] !== {7'd71, 3'd1}) begin
      fails++;
      $display("FAIL sat_entries: got %h %h %h expected %h %h %h", dut_l.u_ram.mem[0],
               dut_l.u_ram.mem[1], dut_l.u_ram.mem[2], {7'd70, 3'd7}, {7'd70, 3'd3},
               {7'd71, 3'd1});
    end
    checks++;
    if (dut_l.track_len_a_q !== 9'd3) begin
      fails++;
      $display("FAIL sat_len: got %0d expected 3", dut_l.track_len_a_q);
    end
    play_req = 1'b1;
    tick; tick;
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (note_valid_l !== 1'b1 || note_l !== ((i % 11 == 10) ? 7'd71 : 7'd70)) begin
        fails++;
        $display("FAIL sat_play_seq[%0d]: got valid %0d note %0d expected 1 %0d",
                 i, note_valid_l, note_l, (i % 11 == 10) ? 71 : 70);
      end
      tick;
    end
    play_req = 1'b0;
    tick;
  endtask

  task automatic test_capacity;
    track_sel = 1'b0; rec_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      ascii = 7'(k);
      tick;
    end
    checks++;
    if (full_a !== 1'b0 || mode_a !== 2'd1) begin
      fails++;
      $display("FAIL cap_before: got full %0d mode %0d expected 0 1", full_a, mode_a);
    end
    ascii = 7'd5;
    tick;
    checks++;
    if (full_a !== 1'b1 || mode_a !== 2'd0 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL cap_full: got full %0d mode %0d busy %0d expected 1 0 0",
               full_a, mode_a, busy_a);
    end
    rec_req = 1'b0; ascii = 7'd6;
    tick;
    checks++;
    if (dut_a.track_len_a_q !== 3'd4 || full_a !== 1'b1) begin
      fails++;
      $display("FAIL cap_len: got len %0d full %0d expected 4 1", dut_a.track_len_a_q, full_a);
    end
    play_req = 1'b1;
    tick; tick;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (note_valid_a !== 1'b1 || note_a !== 7'((i % 4) + 1)) begin
        fails++;
        $display("FAIL cap_play_seq[%0d]: got valid %0d note %0d expected 1 %0d",
                 i, note_valid_a, note_a, (i % 4) + 1);
      end
      tick;
    end
    play_req = 1'b0;
    tick;
  endtask

  task automatic test_async_reset;
    track_sel = 1'b0; rec_req = 1'b1; ascii = 7'd5;
    tick; tick;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mode !== 2'd0 || busy !== 1'b0 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_rec: got mode %0d busy %0d full %0d expected 0 0 0",
               mode, busy, full);
    end
    rec_req = 1'b0;
    #1 reset = 1'b0;
    // Give track A a single entry so a playback can be interrupted.
    rec_req = 1'b1; ascii = 7'd9;
    tick;
    rec_req = 1'b0;
    tick;
    play_req = 1'b1;
    tick; tick;
    checks++;
    if (note_valid !== 1'b1 || note !== 7'd9) begin
      fails++;
      $display("FAIL play_before_reset: got valid %0d note %0d expected 1 9", note_valid, note);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (note !== 7'd0 || note_valid !== 1'b0 || mode !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_play: got note %0d valid %0d mode %0d busy %0d expected 0 0 0 0",
               note, note_valid, mode, busy);
    end
    #1 reset = 1'b0;
    tick; tick; tick;
    checks++;
    if (note_valid !== 1'b0 || mode !== 2'd0) begin
      fails++;
      $display("FAIL empty_play_a: got valid %0d mode %0d expected 0 0", note_valid, mode);
    end
    track_sel = 1'b1;
    tick; tick; tick;
    checks++;
    if (note_valid !== 1'b0 || mode !== 2'd0) begin
      fails++;
      $display("FAIL empty_play_b: got valid %0d mode %0d expected 0 0", note_valid, mode);
    end
    play_req = 1'b0;
    tick;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset;
    test_record_a;
    test_play_a;
    test_back_to_back;
    test_run_saturation;
    test_capacity;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
